auction_seq_ctrl: RTL and testbench
===================================

# auction_seq_ctrl

Sequential controller that runs a sealed-bid second-price auction over the team's 2-input bid comparator datapath. It collects up to N_BIDDERS bids one per cycle through a valid/ready handshake and tracks the highest and second-highest bids incrementally. It then presents the winner index and the clearing price (the second-highest bid) on a held result handshake. It sits in front of the combinational auction netlists and sequences them, so that a wide N-bidder auction reuses a single W-bit pairwise compare per cycle.

## Interface
- N_BIDDERS, 4: number of bidders; legal range 2..16.
- W, 16: bid width in bits, unsigned.
- IDX_W, $clog2(N_BIDDERS): width of the bidder index.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous and active-high.
- start  in  1  one-cycle pulse that opens an auction; honoured only in IDLE.
- close  in  1  one-cycle pulse that ends COLLECT early; honoured only in COLLECT.
- bid_valid  in  1  bid offered.
- bid_ready  out  1  high exactly while state is COLLECT.
- bid_id  in  IDX_W  bidder index.
- bid_value  in  W  bid amount.
- reserve  in  W  reserve price; present only with AUCTION_RESERVE_EN.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed.
- res_winner  out  IDX_W  winning bidder index.
- res_price  out  W  clearing price.
- res_none  out  1  no winner.
- err_dup  out  1  one-cycle pulse on a duplicate or out-of-range bid_id.
- busy  out  1  state is not IDLE.

## Operation
- States and transitions:
  - IDLE: on start, go to COLLECT.
  - COLLECT: on all bidders seen, or on close, go to DONE.
  - DONE: on res_valid && res_ready, go to IDLE.
- Entering COLLECT clears the following: the seen mask (N_BIDDERS bits), top=0, second=0, top_idx=0, count=0.
- A bid is accepted on the edge where bid_valid && bid_ready.
  - If bid_id is new and in range: set its seen bit, increment count, and update the tracker.
  - Otherwise: drop the bid, pulse err_dup, and leave the tracker unchanged.
- Tracker update, for an accepted bid b:
  - If b > top: second←top, top←b, top_idx←bid_id.
  - Else if b > second: second←b.
  - Ties never displace the incumbent. Equal top bids therefore give the win to the earlier arrival, and the price equals the tied value.
- Result in DONE:
  - count==0: res_none=1, res_winner=0, res_price=0.
  - count==1: res_winner=top_idx, res_price=0.
  - Otherwise: res_winner=top_idx, res_price=second.
- All arithmetic is unsigned W-bit compare only; there is no addition and no overflow.

## Timing
- Reset values: state IDLE. The outputs bid_ready, res_valid, res_winner, res_price, res_none, err_dup and busy are all 0.
- Transition edges:
  - The edge that accepts the N_BIDDERS-th unique bid also updates the tracker and enters DONE. res_valid is high in the next cycle, giving 1-cycle latency from the final bid.
  - close moves to DONE on its edge.
  - If a bid and close arrive in the same cycle, the bid is accepted first and counted.
- Result handshake: res_* are registered and held stable while res_valid && !res_ready. On the handshake edge, state returns to IDLE and res_valid falls.
- start is ignored outside IDLE. close is ignored outside COLLECT.
- Asserting rst mid-auction aborts it immediately, with no result. All state returns to reset values asynchronously.

## Configuration
- AUCTION_RESERVE_EN:
  - Defined: the reserve port exists and is sampled when entering COLLECT.
    - If top < reserve in DONE, then res_none=1 and res_price=0.
    - Otherwise res_price = max(second, reserve), which also covers count==1.
  - Undefined: there is no reserve port, and reserve behaves as 0.

## Structure
- Package auction_pkg holds:
  - the state enum typedef (IDLE, COLLECT, DONE);
  - a bid struct typedef {idx, value};
  - the default widths as localparams.
- Sub-module auction_cmp2 (W parameter, combinational) compares the incoming bid against top and against second, and returns the gt_top and gt_second flags. It is instantiated once in the controller.

## Test plan
- N=4, bids (0:100),(1:300),(2:200),(3:50) → res_winner=1, res_price=200, res_valid one cycle after the 4th accept.
- Tie: (2:500),(0:500), then close → res_winner=2, res_price=500.
- Duplicate: (1:10),(1:900),(3:20), close → err_dup pulses once, res_winner=3, res_price=10.
- Single bid (0:77) then close → res_winner=0, res_price=0. Zero bids then close → res_none=1.
- Hold res_ready=0 for 5 cycles → res_* stable. Assert rst during COLLECT after 2 bids → bid_ready=0 and busy=0 immediately, and a new start works.
- AUCTION_RESERVE_EN, reserve=150:
  - bids 100, 120 → res_none=1;
  - bids 300, 100 → res_price=150.

Source files
------------

// File: rtl/auction_pkg.sv
// Shared types and default widths for the sequential second-price auction controller.
package auction_pkg;

  localparam int DEF_N_BIDDERS = 4;
  localparam int DEF_W         = 16;
  localparam int DEF_IDX_W     = $clog2(DEF_N_BIDDERS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  typedef struct packed {
    logic [DEF_IDX_W-1:0] idx;
    logic [DEF_W-1:0]     value;
  } bid_t;

endpackage

// File: rtl/auction_cmp2.sv
// Pairwise unsigned compare of an incoming bid against the current top and second bids.
module auction_cmp2
  import auction_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0] value,
  input  logic [W-1:0] top,
  input  logic [W-1:0] second,
  output logic         gt_top,
  output logic         gt_second
);

  // Strict compares so that equal bids never displace the incumbent.
  assign gt_top    = (value > top);
  assign gt_second = (value > second);

endmodule

// File: rtl/auction_seq_ctrl.sv
// Sequential sealed-bid second-price auction: one bid per cycle, incremental top/second tracking.
// Optional reserve price is enabled by defining AUCTION_RESERVE_EN.
module auction_seq_ctrl
  import auction_pkg::*;
#(
  parameter int N_BIDDERS = DEF_N_BIDDERS,
  parameter int W         = DEF_W,
  parameter int IDX_W     = $clog2(N_BIDDERS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             close,
  input  logic             bid_valid,
  output logic             bid_ready,
  input  logic [IDX_W-1:0] bid_id,
  input  logic [W-1:0]     bid_value,
`ifdef AUCTION_RESERVE_EN
  input  logic [W-1:0]     reserve,
`endif
  output logic             res_valid,
  input  logic             res_ready,
  output logic [IDX_W-1:0] res_winner,
  output logic [W-1:0]     res_price,
  output logic             res_none,
  output logic             err_dup,
  output logic             busy
);

  localparam int CNT_W = $clog2(N_BIDDERS + 1);

  state_t               state_reg;
  logic [N_BIDDERS-1:0] seen_reg;
  logic [W-1:0]         top_reg, second_reg;
  logic [IDX_W-1:0]     top_idx_reg;
  logic [CNT_W-1:0]     count_reg;
  logic                 res_valid_reg, res_none_reg, err_dup_reg;
  logic [IDX_W-1:0]     res_winner_reg;
  logic [W-1:0]         res_price_reg;
`ifdef AUCTION_RESERVE_EN
  logic [W-1:0]         reserve_reg;
`endif

  logic                 take, in_range, is_new, accept, finish;
  logic                 gt_top, gt_second;
  logic [W-1:0]         top_next, second_next, price_next;
  logic [IDX_W-1:0]     top_idx_next;
  logic [CNT_W-1:0]     count_next;
  logic                 none_next;

  auction_cmp2 #(.W(W)) u_cmp (
    .value    (bid_value),
    .top      (top_reg),
    .second   (second_reg),
    .gt_top   (gt_top),
    .gt_second(gt_second)
  );

  assign take     = (state_reg == COLLECT) && bid_valid;
  assign in_range = (32'(bid_id) < 32'(N_BIDDERS));
  assign is_new   = in_range && !seen_reg[bid_id];
  assign accept   = take && is_new;
  // A bid arriving together with close is still counted before the auction ends.
  assign finish   = (state_reg == COLLECT) &&
                    (close || (accept && (count_next == CNT_W'(N_BIDDERS))));

  always_comb begin
    top_next     = top_reg;
    second_next  = second_reg;
    top_idx_next = top_idx_reg;
    count_next   = count_reg;
    if (accept) begin
      count_next = count_reg + CNT_W'(1);
      if (gt_top) begin
        second_next  = top_reg;
        top_next     = bid_value;
        top_idx_next = bid_id;
      end else if (gt_second) begin
        second_next = bid_value;
      end
    end
    price_next = second_next;
    none_next  = (count_next == '0);
`ifdef AUCTION_RESERVE_EN
    if (reserve_reg > second_next) price_next = reserve_reg;
    if (top_next < reserve_reg)    none_next  = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      seen_reg       <= '0;
      top_reg        <= '0;
      second_reg     <= '0;
      top_idx_reg    <= '0;
      count_reg      <= '0;
      res_valid_reg  <= 1'b0;
      res_none_reg   <= 1'b0;
      res_winner_reg <= '0;
      res_price_reg  <= '0;
      err_dup_reg    <= 1'b0;
`ifdef AUCTION_RESERVE_EN
      reserve_reg    <= '0;
`endif
    end else begin
      err_dup_reg <= take && !is_new;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg   <= COLLECT;
            seen_reg    <= '0;
            top_reg     <= '0;
            second_reg  <= '0;
            top_idx_reg <= '0;
            count_reg   <= '0;
`ifdef AUCTION_RESERVE_EN
            reserve_reg <= reserve;
`endif
          end
        end
        COLLECT: begin
          top_reg     <= top_next;
          second_reg  <= second_next;
          top_idx_reg <= top_idx_next;
          count_reg   <= count_next;
          if (accept) seen_reg[bid_id] <= 1'b1;
          // Result is built from the post-update tracker so the final bid is included.
          if (finish) begin
            state_reg      <= DONE;
            res_valid_reg  <= 1'b1;
            res_none_reg   <= none_next;
            res_winner_reg <= none_next ? '0 : top_idx_next;
            res_price_reg  <= none_next ? '0 : price_next;
          end
        end
        DONE: begin
          if (res_ready) begin
            state_reg     <= IDLE;
            res_valid_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bid_ready  = (state_reg == COLLECT);
  assign busy       = (state_reg != IDLE);
  assign res_valid  = res_valid_reg;
  assign res_none   = res_none_reg;
  assign res_winner = res_winner_reg;
  assign res_price  = res_price_reg;
  assign err_dup    = err_dup_reg;

endmodule

// File: tb/tb_auction_seq_ctrl.sv
// Self-checking bench for auction_seq_ctrl: directed table, reset abort, randomized auctions vs model.
`timescale 1ns/1ps
module tb_auction_seq_ctrl;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst, start, close, bid_valid, bid_ready;
  logic [IW-1:0] bid_id;
  logic [W-1:0]  bid_value;
`ifdef AUCTION_RESERVE_EN
  logic [W-1:0]  reserve;
`endif
  logic          res_valid, res_ready, res_none, err_dup, busy;
  logic [IW-1:0] res_winner;
  logic [W-1:0]  res_price;

  int total = 0;
  int bad   = 0;
  int rsv   = 0;

  int cur_n;
  int cur_ids[8];
  int cur_vals[8];
  int acc_ids[$];
  int acc_vals[$];
  int dup_cnt, fed_cnt;

  typedef struct {
    int              n;
    int              rsv;
    int              hold;
    logic [5:0][1:0] ids;
    logic [5:0][15:0] vals;
    int              ew, ep, en, ed;
  } vec_t;

  vec_t tbl[16];
  int   n_tbl = 0;

  auction_seq_ctrl #(.N_BIDDERS(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .close     (close),
    .bid_valid (bid_valid),
    .bid_ready (bid_ready),
    .bid_id    (bid_id),
    .bid_value (bid_value),
`ifdef AUCTION_RESERVE_EN
    .reserve   (reserve),
`endif
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_winner(res_winner),
    .res_price (res_price),
    .res_none  (res_none),
    .err_dup   (err_dup),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input int n, input int rs, input int hold,
                         input int ew, input int ep, input int en, input int ed,
                         input int i0, input int v0, input int i1, input int v1,
                         input int i2, input int v2, input int i3, input int v3,
                         input int i4, input int v4);
    vec_t v;
    int ia[5];
    int va[5];
    ia = '{i0, i1, i2, i3, i4};
    va = '{v0, v1, v2, v3, v4};
    v.n = n; v.rsv = rs; v.hold = hold;
    v.ew = ew; v.ep = ep; v.en = en; v.ed = ed;
    v.ids = '0; v.vals = '0;
    for (int k = 0; k < 5; k++) begin
      v.ids[k]  = IW'(ia[k]);
      v.vals[k] = W'(va[k]);
    end
    tbl[n_tbl] = v;
    n_tbl++;
  endtask

  // Opens an auction, offers cur_* bids, and closes it unless all bidders were seen.
  task automatic feed(input bit comb_close);
    bit seen[N];
    int uniq;
    bit done;
    uniq = 0; done = 1'b0;
    for (int k = 0; k < N; k++) seen[k] = 1'b0;
    acc_ids.delete(); acc_vals.delete();
    dup_cnt = 0; fed_cnt = 0;
`ifdef AUCTION_RESERVE_EN
    reserve = W'(rsv);
`endif
    start = 1'b1;
    step();
    start = 1'b0;
    check("open_ready", int'(bid_ready), 1);
    check("open_busy", int'(busy), 1);
    for (int i = 0; i < cur_n && !done; i++) begin
      bid_valid = 1'b1;
      bid_id    = IW'(cur_ids[i]);
      bid_value = W'(cur_vals[i]);
      close     = comb_close && (i == cur_n - 1);
      step();
      bid_valid = 1'b0;
      close     = 1'b0;
      fed_cnt++;
      dup_cnt += int'(err_dup);
      if (!seen[cur_ids[i]]) begin
        seen[cur_ids[i]] = 1'b1;
        uniq++;
        acc_ids.push_back(cur_ids[i]);
        acc_vals.push_back(cur_vals[i]);
      end
      done = (uniq == N) || (comb_close && (i == cur_n - 1));
      check("valid_after_bid", int'(res_valid), int'(done));
      check("ready_after_bid", int'(bid_ready), int'(!done));
    end
    if (!done) begin
      close = 1'b1;
      step();
      close = 1'b0;
      dup_cnt += int'(err_dup);
      check("valid_after_close", int'(res_valid), 1);
    end
  endtask

  // Checks the held result for hold+1 cycles (with ignored start/close), then handshakes.
  task automatic finish_check(input string tag, input int ew, input int ep,
                              input int en, input int ed, input int hold);
    check({tag, "_dup"}, dup_cnt, ed);
    for (int h = 0; h <= hold; h++) begin
      check({tag, "_valid"}, int'(res_valid), 1);
      check({tag, "_winner"}, int'(res_winner), ew);
      check({tag, "_price"}, int'(res_price), ep);
      check({tag, "_none"}, int'(res_none), en);
      if (h < hold) begin
        start = (h == 0);
        close = (h == 0);
        step();
        start = 1'b0;
        close = 1'b0;
      end
    end
    $display("auction %s: winner=%0d price=%0d none=%0d dups=%0d",
             tag, res_winner, res_price, res_none, dup_cnt);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check({tag, "_valid_drop"}, int'(res_valid), 0);
    check({tag, "_busy_idle"}, int'(busy), 0);
    check({tag, "_ready_idle"}, int'(bid_ready), 0);
  endtask

  // Second-price reference: earliest maximum wins, price is the best of the other bids.
  task automatic model(output int ew, output int ep, output int en);
    int best, bpos, sec;
    best = -1; bpos = 0; sec = 0;
    for (int i = 0; i < acc_vals.size(); i++)
      if (acc_vals[i] > best) begin
        best = acc_vals[i];
        bpos = i;
      end
    for (int i = 0; i < acc_vals.size(); i++)
      if (i != bpos && acc_vals[i] > sec) sec = acc_vals[i];
    en = (acc_vals.size() == 0 || best < rsv) ? 1 : 0;
    ew = (en == 1) ? 0 : acc_ids[bpos];
    ep = (en == 1) ? 0 : ((sec > rsv) ? sec : rsv);
  endtask

  initial begin
    int ew, ep, en;
    rst = 1'b1; start = 1'b0; close = 1'b0; bid_valid = 1'b0;
    bid_id = '0; bid_value = '0; res_ready = 1'b0;
`ifdef AUCTION_RESERVE_EN
    reserve = '0;
`endif

    //       n rsv hold  w    p  none dup   bids (id,value)
    add_vec(4, 0,  0,   1, 200, 0, 0,   0,100, 1,300, 2,200, 3,50,  0,0);
    add_vec(2, 0,  1,   2, 500, 0, 0,   2,500, 0,500, 0,0,   0,0,   0,0);
    add_vec(3, 0,  2,   3, 10,  0, 1,   1,10,  1,900, 3,20,  0,0,   0,0);
    add_vec(1, 0,  0,   0, 0,   0, 0,   0,77,  0,0,   0,0,   0,0,   0,0);
    add_vec(0, 0,  0,   0, 0,   1, 0,   0,0,   0,0,   0,0,   0,0,   0,0);
    add_vec(3, 0,  5,   2, 60,  0, 0,   3,40,  2,60,  1,60,  0,0,   0,0);
    add_vec(2, 0,  0,   0, 0,   0, 0,   0,0,   1,0,   0,0,   0,0,   0,0);
    add_vec(5, 0,  1,   2, 7,   0, 1,   0,5,   0,9,   1,7,   2,8,   3,1);
`ifdef AUCTION_RESERVE_EN
    add_vec(2, 150, 0,  0, 0,   1, 0,   0,100, 1,120, 0,0,   0,0,   0,0);
    add_vec(2, 150, 0,  0, 150, 0, 0,   0,300, 1,100, 0,0,   0,0,   0,0);
    add_vec(1, 150, 0,  2, 150, 0, 0,   2,200, 0,0,   0,0,   0,0,   0,0);
`endif

    step(); step();
    check("rst_bid_ready", int'(bid_ready), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_res_winner", int'(res_winner), 0);
    check("rst_res_price", int'(res_price), 0);
    check("rst_res_none", int'(res_none), 0);
    check("rst_err_dup", int'(err_dup), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;
    step();

    // Abort an auction mid-collect; outputs must drop before the next clock edge.
    start = 1'b1; step(); start = 1'b0;
    bid_valid = 1'b1; bid_id = 2'd0; bid_value = 16'd100; step();
    bid_id = 2'd1; bid_value = 16'd300; step();
    bid_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("abort_bid_ready", int'(bid_ready), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_res_valid", int'(res_valid), 0);
    step();
    rst = 1'b0;
    step();

    for (int k = 0; k < n_tbl; k++) begin
      cur_n = tbl[k].n;
      rsv   = tbl[k].rsv;
      for (int j = 0; j < 6; j++) begin
        cur_ids[j]  = int'(tbl[k].ids[j]);
        cur_vals[j] = int'(tbl[k].vals[j]);
      end
      feed(1'b0);
      finish_check($sformatf("vec%0d", k), tbl[k].ew, tbl[k].ep, tbl[k].en, tbl[k].ed, tbl[k].hold);
    end

    for (int r = 0; r < 40; r++) begin
      cur_n = $urandom_range(0, 7);
      for (int j = 0; j < cur_n; j++) begin
        cur_ids[j]  = $urandom_range(0, N - 1);
        cur_vals[j] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535)
                                                  : $urandom_range(0, 8) * 40;
      end
`ifdef AUCTION_RESERVE_EN
      rsv = $urandom_range(0, 6) * 40;
`else
      rsv = 0;
`endif
      feed(1'($urandom_range(0, 1)));
      model(ew, ep, en);
      finish_check($sformatf("rand%0d", r), ew, ep, en, fed_cnt - acc_ids.size(),
                   $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
